// File: rtl/mux_3x1_pkg.sv
// Core types shared by the TinyV datapath selectors: default data width and
// the 2-bit select code.
package mux_3x1_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    SEL_A       = 2'b00,
    SEL_B       = 2'b01,
    SEL_C       = 2'b10,
    SEL_INVALID = 2'b11
  } sel_t;

endpackage

// File: rtl/mux_3x1_comb.sv
// Pure combinational three-way selector with an illegal-select flag, usable
// anywhere in the datapath where no register stage is wanted.
module mux_3x1_comb
  import mux_3x1_pkg::*;
#(
  parameter int DATA_WIDTH = mux_3x1_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] c,
  input  logic [1:0]            sel,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  sel_err
);

  // Unknown or illegal select codes fall through to the zero default.
  always_comb begin
    result  = '0;
    sel_err = 1'b0;
    case (sel)
      SEL_A:       result = a;
      SEL_B:       result = b;
      SEL_C:       result = c;
      SEL_INVALID: sel_err = 1'b1;
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/mux_3x1.sv
// Three-input selector for operand forwarding: combinational result for
// same-cycle use plus an enabled register stage and a sticky error flag.
module mux_3x1
  import mux_3x1_pkg::*;
#(
  parameter int DATA_WIDTH = mux_3x1_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [DATA_WIDTH-1:0] C,
  input  logic [1:0]            sel,
  input  logic                  en,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_q,
  output logic                  sel_err,
  output logic                  sel_err_q
);

  mux_3x1_comb #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_comb (
    .a       (A),
    .b       (B),
    .c       (C),
    .sel     (sel),
    .result  (result),
    .sel_err (sel_err)
  );

  // sel_err_q only ever sets; the one way back to zero is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      sel_err_q <= 1'b0;
    end else if (en) begin
      result_q  <= result;
      sel_err_q <= sel_err_q | sel_err;
    end
  end

endmodule

// File: tb/tb_mux_3x1.sv
// Self-checking bench for mux_3x1: directed vector table, register/sticky
// sequences, async reset pulse, random sweep and 8/64-bit width instances.
module tb_mux_3x1;

  logic        clk;
  logic        rst_n;
  logic [31:0] a, b, c;
  logic [1:0]  sel;
  logic        en;
  logic [31:0] result, result_q;
  logic        sel_err, sel_err_q;

  logic [7:0]  a8, b8, c8, result8, result8_q;
  logic        sel_err8, sel_err8_q;
  logic [63:0] a64, b64, c64, result64, result64_q;
  logic        sel_err64, sel_err64_q;
  logic [1:0]  selw;
  logic        enw;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q;
  logic        exp_err;

  typedef struct {
    logic [31:0] a, b, c;
    logic [1:0]  sel;
    logic [31:0] exp_result;
    logic        exp_err;
  } vec_t;

  vec_t vecs[4];

  mux_3x1 #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .sel(sel), .en(en),
    .result(result), .result_q(result_q), .sel_err(sel_err), .sel_err_q(sel_err_q)
  );

  mux_3x1 #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .C(c8), .sel(selw), .en(enw),
    .result(result8), .result_q(result8_q), .sel_err(sel_err8), .sel_err_q(sel_err8_q)
  );

  mux_3x1 #(.DATA_WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .A(a64), .B(b64), .C(c64), .sel(selw), .en(enw),
    .result(result64), .result_q(result64_q), .sel_err(sel_err64), .sel_err_q(sel_err64_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pick an entry from the input list; anything past the list is zero.
  function automatic logic [31:0] refSelect(input logic [31:0] ia, ib, ic,
                                            input logic [1:0] isel);
    logic [31:0] choices[3];
    choices[0] = ia;
    choices[1] = ib;
    choices[2] = ic;
    if (int'(isel) < 3) return choices[isel];
    return 32'h0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ia, ib, ic,
                               input logic [1:0] isel, input logic ien);
    a   = ia;
    b   = ib;
    c   = ic;
    sel = isel;
    en  = ien;
  endtask

  task automatic checkComb();
    checkOutput("result", {32'h0, result}, {32'h0, refSelect(a, b, c, sel)});
    checkOutput("sel_err", {63'h0, sel_err}, {63'h0, (sel == 2'b11)});
  endtask

  // One rising edge: advance the model, then check both registers just after.
  task automatic tick();
    @(posedge clk);
    if (rst_n && en) begin
      exp_q = refSelect(a, b, c, sel);
      if (sel == 2'b11) exp_err = 1'b1;
    end
    #1;
    checkOutput("result_q", {32'h0, result_q}, {32'h0, exp_q});
    checkOutput("sel_err_q", {63'h0, sel_err_q}, {63'h0, exp_err});
  endtask

  // Reset pulse placed between edges; registers must clear with no clock.
  task automatic resetPulse();
    #2;
    rst_n = 1'b0;
    #1;
    exp_q   = '0;
    exp_err = 1'b0;
    checkOutput("rst_result_q", {32'h0, result_q}, 64'h0);
    checkOutput("rst_sel_err_q", {63'h0, sel_err_q}, 64'h0);
    checkComb();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{32'hAAAA, 32'hBBBB, 32'hCCCC, 2'b00, 32'hAAAA, 1'b0};
    vecs[1] = '{32'hAAAA, 32'hBBBB, 32'hCCCC, 2'b01, 32'hBBBB, 1'b0};
    vecs[2] = '{32'hAAAA, 32'hBBBB, 32'hCCCC, 2'b10, 32'hCCCC, 1'b0};
    vecs[3] = '{32'hAAAA, 32'hBBBB, 32'hCCCC, 2'b11, 32'h0000, 1'b1};

    exp_q   = '0;
    exp_err = 1'b0;
    rst_n   = 1'b0;
    selw    = 2'b00;
    enw     = 1'b0;
    a8 = 8'hFF;  b8 = 8'h55;  c8 = 8'h80;
    a64 = '1;    b64 = 64'h5555_5555_5555_5555;  c64 = 64'h8000_0000_0000_0000;
    applyStimulus(32'hAAAA, 32'hBBBB, 32'hCCCC, 2'b00, 1'b1);

    // Reset state; combinational path must already be live.
    #2;
    checkOutput("reset_result_q", {32'h0, result_q}, 64'h0);
    checkOutput("reset_sel_err_q", {63'h0, sel_err_q}, 64'h0);
    checkOutput("reset_result", {32'h0, result}, 64'hAAAA);
    tick();
    checkOutput("reset_held_result_q", {32'h0, result_q}, 64'h0);
    rst_n = 1'b1;

    // Directed table, 10 ns per step, registers disabled.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sel, 1'b0);
      #1;
      checkOutput("vec_result", {32'h0, result}, {32'h0, vecs[i].exp_result});
      checkOutput("vec_sel_err", {63'h0, sel_err}, {63'h0, vecs[i].exp_err});
    end
    tick();
    checkOutput("disabled_result_q", {32'h0, result_q}, 64'h0);

    // Illegal select latched, then sticky across a legal select.
    applyStimulus(32'hAAAA, 32'hBBBB, 32'hCCCC, 2'b11, 1'b1);
    tick();
    checkOutput("sticky_set", {63'h0, sel_err_q}, 64'h1);
    applyStimulus(32'hAAAA, 32'hBBBB, 32'hCCCC, 2'b00, 1'b1);
    tick();
    checkOutput("sticky_hold", {63'h0, sel_err_q}, 64'h1);
    checkOutput("after_err_result_q", {32'h0, result_q}, 64'hAAAA);
    resetPulse();

    // Enable load, then hold with en low while the input moves.
    applyStimulus(32'hAAAA, 32'hBBBB, 32'hCCCC, 2'b01, 1'b1);
    tick();
    checkOutput("load_b", {32'h0, result_q}, 64'hBBBB);
    applyStimulus(32'hAAAA, 32'hBBBB, 32'hCCCC, 2'b10, 1'b0);
    tick();
    checkOutput("hold_b", {32'h0, result_q}, 64'hBBBB);
    checkOutput("hold_comb_c", {32'h0, result}, 64'hCCCC);

    // Load C with the error flag set, then pulse reset mid-cycle.
    applyStimulus(32'hAAAA, 32'hBBBB, 32'hCCCC, 2'b11, 1'b1);
    tick();
    applyStimulus(32'hAAAA, 32'hBBBB, 32'hCCCC, 2'b10, 1'b1);
    tick();
    checkOutput("preload_c", {32'h0, result_q}, 64'hCCCC);
    checkOutput("preload_err", {63'h0, sel_err_q}, 64'h1);
    resetPulse();
    checkOutput("rst_comb_c", {32'h0, result}, 64'hCCCC);
    tick();

    // Random sweep against the reference model.
    for (int i = 0; i < 1000; i++) begin
      applyStimulus($urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) != 0));
      #1;
      checkComb();
      if (i == 500) resetPulse();
      tick();
    end

    // Width instances: full-width values, no truncation or extension.
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      selw = 2'(s);
      enw  = 1'b1;
      #1;
      checkOutput("w8_result", {56'h0, result8},
                  (s == 0) ? 64'hFF : (s == 1) ? 64'h55 : (s == 2) ? 64'h80 : 64'h0);
      checkOutput("w64_result", result64,
                  (s == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (s == 1) ? 64'h5555_5555_5555_5555 :
                  (s == 2) ? 64'h8000_0000_0000_0000 : 64'h0);
      checkOutput("w64_sel_err", {63'h0, sel_err64}, {63'h0, (s == 3)});
      @(posedge clk);
      #1;
      checkOutput("w64_result_q", result64_q,
                  (s == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (s == 1) ? 64'h5555_5555_5555_5555 :
                  (s == 2) ? 64'h8000_0000_0000_0000 : 64'h0);
      checkOutput("w8_result_q", {56'h0, result8_q},
                  (s == 0) ? 64'hFF : (s == 1) ? 64'h55 : (s == 2) ? 64'h80 : 64'h0);
    end
    checkOutput("w8_sticky", {63'h0, sel_err8_q}, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
